cbd_sampler: RTL and testbench

- Parametrised centered-binomial-distribution sampler for the lattice-crypto datapath; successor to the fixed eta=3, 48-bit-burst sampler.
- Consumes a LSB-first stream of pseudo-random words from the hash/XOF buffer over a valid/ready handshake, with a word address counter.
- Emits one coefficient per cycle over a valid/ready handshake, reduced into [0, Q-1], until N_COEF coefficients are produced. Then pulses done.
- Supports any ETA and input word width; coefficients may straddle input words, and leftover bits are carried, not discarded.

---
 rtl/cbd_sampler.sv | 181 ++++++++++++++++++
 tb/tb_cbd_sampler.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/cbd_sampler.sv
// Centered-binomial-distribution sampler: turns an LSB-first stream of random
// words into N_COEF coefficients, each the popcount difference of two ETA-bit
// halves, reduced into [0, Q-1]. Leftover bits are carried between words.
// Optional macro CBD_SIGNED_OUT_EN: emit the raw signed difference
// (sign-extended to COEF_W) instead of the Q-wrapped value.
//
// Ports:
//   clk, reset      clock (rising edge), asynchronous active-low reset
//   start           one-cycle run request, honoured in IDLE only
//   in_data/in_valid/in_ready   random word input handshake, address = next word index
//   out_coef/out_valid/out_ready  coefficient output handshake, one per cycle
//   busy            high in RUN and DONE
//   done            one-cycle pulse after the last coefficient is accepted
module cbd_sampler #(
    parameter int ETA    = 3,
    parameter int IN_W   = 64,
    parameter int COEF_W = 12,
    parameter int Q      = 3329,
    parameter int N_COEF = 256,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [IN_W-1:0]   in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [ADDR_W-1:0] address,
    output logic [COEF_W-1:0] out_coef,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              busy,
    output logic              done
);

    localparam int CB    = 2 * ETA;
    localparam int BUF_W = IN_W + CB - 1;
    localparam int FW    = $clog2(BUF_W + 1);
    localparam int WORDS = (N_COEF * CB + IN_W - 1) / IN_W;
    localparam int WW    = $clog2(WORDS + 1);
    localparam int NW    = $clog2(N_COEF + 1);
    localparam int PW    = $clog2(ETA + 1);

    localparam logic [FW-1:0] CB_F    = FW'(CB);
    localparam logic [FW-1:0] IN_F    = FW'(IN_W);
    localparam logic [WW-1:0] WORDS_W = WW'(WORDS);
    localparam logic [NW-1:0] NCOEF_N = NW'(N_COEF);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             state, state_nxt;
    logic [BUF_W-1:0]   bit_buf, bit_buf_nxt;
    logic [FW-1:0]      fill, fill_nxt;
    logic [NW-1:0]      coef_cnt, coef_cnt_nxt;
    logic [WW-1:0]      word_cnt, word_cnt_nxt;
    logic [ADDR_W-1:0]  address_nxt;
    logic               in_ready_nxt;
    logic               in_acc, out_acc;
    logic [BUF_W-1:0]   in_ext, keep_mask;
    logic [PW-1:0]      pop_a, pop_b;
    logic [COEF_W-1:0]  a_ext, b_ext;

    function automatic logic [PW-1:0] popcnt(input logic [ETA-1:0] v);
        logic [PW-1:0] cnt;
        cnt = '0;
        for (int i = 0; i < ETA; i++) begin
            cnt = cnt + PW'(v[i]);
        end
        return cnt;
    endfunction

    assign in_acc    = in_valid && in_ready;
    assign out_acc   = out_valid && out_ready;
    assign in_ext    = {{(BUF_W - IN_W){1'b0}}, in_data};
    // Bits below fill are still pending; everything at and above fill is replaced.
    assign keep_mask = ~({BUF_W{1'b1}} << fill);

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Datapath registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bit_buf  <= '0;
            fill     <= '0;
            coef_cnt <= '0;
            word_cnt <= '0;
            address  <= '0;
            in_ready <= 1'b0;
        end else begin
            bit_buf  <= bit_buf_nxt;
            fill     <= fill_nxt;
            coef_cnt <= coef_cnt_nxt;
            word_cnt <= word_cnt_nxt;
            address  <= address_nxt;
            in_ready <= in_ready_nxt;
        end
    end

    // Next-state and datapath update
    always_comb begin
        state_nxt    = state;
        bit_buf_nxt  = bit_buf;
        fill_nxt     = fill;
        coef_cnt_nxt = coef_cnt;
        word_cnt_nxt = word_cnt;
        address_nxt  = address;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_nxt    = S_RUN;
                    bit_buf_nxt  = '0;
                    fill_nxt     = '0;
                    coef_cnt_nxt = '0;
                    word_cnt_nxt = '0;
                    address_nxt  = '0;
                end
            end
            S_RUN: begin
                // in_acc needs fill < CB and out_acc needs fill >= CB, so at most one fires.
                if (in_acc) begin
                    bit_buf_nxt  = (bit_buf & keep_mask) | (in_ext << fill);
                    fill_nxt     = fill + IN_F;
                    word_cnt_nxt = word_cnt + WW'(1);
                    address_nxt  = address + ADDR_W'(1);
                end else if (out_acc) begin
                    bit_buf_nxt  = bit_buf >> CB;
                    fill_nxt     = fill - CB_F;
                    coef_cnt_nxt = coef_cnt + NW'(1);
                    if (coef_cnt == NCOEF_N - NW'(1)) begin
                        state_nxt = S_DONE;
                    end
                end
            end
            S_DONE: begin
                // Residual bits of the final word are dropped here.
                state_nxt   = S_IDLE;
                bit_buf_nxt = '0;
                fill_nxt    = '0;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
        // in_ready is registered, so it is computed from the values the counters take next.
        in_ready_nxt = (state_nxt == S_RUN) && (fill_nxt < CB_F) && (word_cnt_nxt < WORDS_W);
    end

    assign pop_a = popcnt(bit_buf[ETA-1:0]);
    assign pop_b = popcnt(bit_buf[CB-1:ETA]);
    assign a_ext = COEF_W'(pop_a);
    assign b_ext = COEF_W'(pop_b);

    // Outputs
    always_comb begin
        busy      = (state != S_IDLE);
        done      = (state == S_DONE);
        out_valid = (state == S_RUN) && (fill >= CB_F) && (coef_cnt < NCOEF_N);
`ifdef CBD_SIGNED_OUT_EN
        // Modular subtraction at COEF_W bits is exactly the sign-extended difference.
        out_coef  = a_ext - b_ext;
`else
        if (pop_a >= pop_b) begin
            out_coef = a_ext - b_ext;
        end else begin
            out_coef = COEF_W'(Q) - (b_ext - a_ext);
        end
`endif
    end

endmodule

// File: tb/tb_cbd_sampler.sv
module tb_cbd_sampler;

    localparam int N     = 256;
    localparam int WORDS = 24;

    typedef struct {
        logic [5:0] pat;
        int         diff;
    } vec_t;

    vec_t tbl [16];

    logic        clk;
    logic        reset;
    logic        start;
    logic [63:0] in_data;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  address;
    logic [11:0] out_coef;
    logic        out_valid;
    logic        out_ready;
    logic        busy;
    logic        done;

    logic        e2_start;
    logic [63:0] e2_in_data;
    logic        e2_in_valid;
    logic        e2_in_ready;
    logic [7:0]  e2_address;
    logic [11:0] e2_out_coef;
    logic        e2_out_valid;
    logic        e2_out_ready;
    logic        e2_busy;
    logic        e2_done;

    int checks = 0;
    int errors = 0;
    logic [63:0] words [0:WORDS-1];

    cbd_sampler dut (
        .clk(clk), .reset(reset), .start(start),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .address(address), .out_coef(out_coef), .out_valid(out_valid),
        .out_ready(out_ready), .busy(busy), .done(done)
    );

    cbd_sampler #(.ETA(2)) dut_e2 (
        .clk(clk), .reset(reset), .start(e2_start),
        .in_data(e2_in_data), .in_valid(e2_in_valid), .in_ready(e2_in_ready),
        .address(e2_address), .out_coef(e2_out_coef), .out_valid(e2_out_valid),
        .out_ready(e2_out_ready), .busy(e2_busy), .done(e2_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", nm, act, req);
        end
    endtask

    function automatic logic [11:0] exp_of(input int d);
`ifdef CBD_SIGNED_OUT_EN
        return 12'(d);
`else
        return (d >= 0) ? 12'(d) : 12'(3329 + d);
`endif
    endfunction

    // dsel 0: stream built from the vector table; dsel 1: all-zero words
    task automatic load(input int dsel);
        logic [1535:0] s;
        s = '0;
        if (dsel == 0) begin
            for (int k = 0; k < N; k++) s[6*k +: 6] = tbl[k % 16].pat;
        end
        for (int w = 0; w < WORDS; w++) words[w] = s[64*w +: 64];
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_in_ready"},  in_ready,  0);
        chk({tag, "_out_valid"}, out_valid, 0);
        chk({tag, "_out_coef"},  out_coef,  0);
        chk({tag, "_address"},   address,   0);
        chk({tag, "_busy"},      busy,      0);
        chk({tag, "_done"},      done,      0);
    endtask

    task automatic run(input int dsel, input bit bp, input int abort_at);
        int   k, wcnt, cyc, busy_cyc, idx;
        bit   fin, stalled, addr_done, in_acc, out_acc;
        logic [11:0] held;
        k = 0; wcnt = 0; cyc = 0; busy_cyc = 0;
        fin = 0; stalled = 0; addr_done = 0; held = '0;
        load(dsel);
        @(posedge clk); #1;
        start = 1; in_valid = 1; in_data = words[0]; out_ready = 1;
        @(posedge clk); #1;
        start = 0;
        while (!fin && cyc < 5000) begin
            @(negedge clk);
            cyc++;
            if (busy) busy_cyc++;
            in_acc  = in_valid && in_ready;
            out_acc = out_valid && out_ready;
            if (stalled && out_valid) chk("stall_hold", out_coef, held);
            stalled = out_valid && !out_ready;
            held    = out_coef;
            if (wcnt == 1 && !addr_done) begin
                chk("addr_after_first", address, 1);
                addr_done = 1;
            end
            if (out_acc) begin
                if (dsel == 0 && k == 10) chk("straddle_words_in", wcnt, 2);
                chk("coef", out_coef, (dsel == 0) ? exp_of(tbl[k % 16].diff) : 12'd0);
                k++;
            end
            if (done) begin
                start = 0; in_valid = 0;
                chk("done_coefs", k, N);
                chk("done_words", wcnt, WORDS);
                chk("done_address", address, WORDS);
                chk("done_busy", busy, 1);
                if (!bp) chk("busy_cycles", busy_cyc, N + WORDS + 1);
                @(negedge clk);
                chk("done_single", done, 0);
                chk("busy_fall", busy, 0);
                fin = 1;
            end else if (abort_at > 0 && k == abort_at) begin
                #2 reset = 0;
                #1 check_reset_vals("abort");
                @(posedge clk); #1;
                chk("abort_no_done", done, 0);
                chk("abort_busy", busy, 0);
                start = 0; in_valid = 0; out_ready = 0;
                reset = 1;
                fin = 1;
            end else begin
                @(posedge clk); #1;
                if (in_acc) wcnt++;
                idx = (wcnt < WORDS) ? wcnt : WORDS - 1;
                if (bp) begin
                    in_valid  = ($urandom_range(0, 2) != 0);
                    out_ready = ~out_ready;
                    start     = ($urandom_range(0, 5) == 0);
                end
                in_data = in_valid ? words[idx] : ~words[idx];
            end
        end
        if (!fin) begin
            checks++; errors++;
            $display("FAIL run_timeout cycles=%0d required<5000", cyc);
        end
        start = 0; in_valid = 0;
    endtask

    task automatic run_e2();
        int k, wc, cyc;
        bit fin;
        k = 0; wc = 0; cyc = 0; fin = 0;
        @(posedge clk); #1;
        e2_start = 1; e2_in_valid = 1; e2_in_data = '1; e2_out_ready = 1;
        @(posedge clk); #1;
        e2_start = 0;
        while (!fin && cyc < 5000) begin
            @(negedge clk);
            cyc++;
            if (e2_in_valid && e2_in_ready) wc++;
            if (e2_out_valid && e2_out_ready) begin
                chk("e2_coef", e2_out_coef, 0);
                k++;
            end
            if (e2_done) begin
                e2_in_valid = 0;
                chk("e2_done_coefs", k, N);
                chk("e2_done_words", wc, 16);
                chk("e2_done_address", e2_address, 16);
                fin = 1;
            end
        end
        if (!fin) begin
            checks++; errors++;
            $display("FAIL e2_timeout cycles=%0d required<5000", cyc);
        end
    endtask

    initial begin
        // 6-bit pattern (bit 0 = first bit consumed) and hand-computed a-b.
        // Entries 0/1 form the low 12 bits 0xE07 of word 0; entry 10 straddles words 0/1.
        tbl[0]  = '{6'b000111,  3};
        tbl[1]  = '{6'b111000, -3};
        tbl[2]  = '{6'b000000,  0};
        tbl[3]  = '{6'b000001,  1};
        tbl[4]  = '{6'b001000, -1};
        tbl[5]  = '{6'b111111,  0};
        tbl[6]  = '{6'b101010, -1};
        tbl[7]  = '{6'b010101,  1};
        tbl[8]  = '{6'b000011,  2};
        tbl[9]  = '{6'b011000, -2};
        tbl[10] = '{6'b001111,  2};
        tbl[11] = '{6'b110001, -1};
        tbl[12] = '{6'b100110,  1};
        tbl[13] = '{6'b111100, -2};
        tbl[14] = '{6'b011011,  0};
        tbl[15] = '{6'b100000, -1};

        reset = 0; start = 0; in_data = '0; in_valid = 0; out_ready = 0;
        e2_start = 0; e2_in_data = '0; e2_in_valid = 0; e2_out_ready = 0;
        #1 check_reset_vals("por");
        #11 reset = 1;
        repeat (2) @(posedge clk);
        #3 reset = 0;
        #1 check_reset_vals("idle_rst");
        #2 reset = 1;

        run(0, 0, 0);    // table stream, no backpressure
        run(1, 0, 0);    // all-zero words
        run(0, 1, 0);    // backpressure, sparse in_valid, stray start pulses
        run(0, 0, 100);  // reset after 100 coefficients
        run(0, 0, 0);    // restart reproduces the stream from address 0
        run_e2();        // ETA=2, all-ones words

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
